bcd_char_serializer: RTL and testbench
======================================

Name: bcd_char_serializer

Overview:
- Downstream consumer of the binary-to-BCD converter in the measurement readout path (voltage/frequency/period readouts).
- Latches a packed BCD word with sign and decimal-point position when the converter signals completion.
- Emits a fixed-width ASCII character frame, one character per valid/ready handshake, to the on-screen text renderer.
- Handles sign, decimal point, leading-zero blanking and invalid-digit marking.

Parameters:
- DIGITS, 6, number of BCD digits in dat_bcd_i (1..15).
- DP_W, 4, width of dp_pos_i.

Ports:
- clk_i  input  1  system clock, all state on rising edge.
- rst_n_i  input  1  asynchronous active-low reset.
- load_i  input  1  one-cycle pulse: dat_bcd_i, neg_i and dp_pos_i are valid (driven from converter done rising edge).
- dat_bcd_i  input  4*DIGITS  packed BCD; digit k at bits [4k+3:4k]; digit DIGITS-1 is most significant.
- neg_i  input  1  value is negative.
- dp_pos_i  input  DP_W  digits right of decimal point; 0 means no point.
- char_o  output  8  ASCII character.
- char_valid_o  output  1  char_o valid.
- char_ready_i  input  1  renderer accepts char_o.
- first_o  output  1  qualifies first character of frame.
- last_o  output  1  qualifies final character of frame.
- busy_o  output  1  frame in progress.
- overrun_o  output  1  one-cycle pulse: load_i dropped while busy.

Behaviour:
- Reset (async, rst_n_i low): all outputs 0; FSM in IDLE; latched data cleared. Reset mid-frame aborts the frame immediately; no further characters are emitted.
- FSM states: IDLE, SIGN, DIGIT, POINT, DRAIN.
- IDLE:
  - load_i=1 latches inputs, clears the digit index to DIGITS-1 and the nonzero_seen flag, and moves to SIGN.
  - busy_o goes high on the next cycle.
- Latency: first char_valid_o is asserted in the cycle after load_i.
- Handshake:
  - A transfer occurs when char_valid_o && char_ready_i.
  - While valid && !ready, char_o, first_o and last_o hold stable.
  - When ready is held high, one character is emitted per cycle.
- dp_pos clamp: a latched dp_pos >= DIGITS is clamped to DIGITS-1.
- SIGN: emits '-' (0x2D) if neg, else ' ' (0x20); first_o=1. On transfer, moves to DIGIT.
- DIGIT: emits digit at the current index.
  - Value 0..9: emitted as 0x30+value.
  - Value 10..15: emitted as '?' (0x3F), and counts as nonzero.
  - Blanking: if nonzero_seen=0, digit=0, and index > dp_pos and index > 0, emit ' ' (0x20).
  - Any emitted non-blank character sets nonzero_seen.
  - On transfer:
    - index=0: frame complete, go to DRAIN.
    - else if dp_pos != 0 and index == dp_pos: go to POINT.
    - else: decrement index, stay in DIGIT.
- POINT: emits '.' (0x2E). On transfer, decrements index and returns to DIGIT.
- Frame length: 1 + DIGITS + (dp_pos != 0 ? 1 : 0). last_o accompanies the digit-0 character.
- DRAIN: char_valid_o=0, busy_o=0 for one cycle, then IDLE. The earliest next load is the cycle after DRAIN; back-to-back frames are separated by at least 2 idle cycles.
- load_i while busy_o=1 or in DRAIN: the load is ignored, latched data is unchanged, and overrun_o pulses high for exactly one cycle.
- char_ready_i while char_valid_o=0: ignored.

Optional Feature:
- Macro BCD_CHAR_ZERO_BLANK_EN.
- Defined: leading-zero blanking active as described above.
- Undefined:
  - No blanking; every digit is emitted as its numeral.
  - nonzero_seen logic is removed.
  - Frame length and timing are identical.

Test Plan:
- DIGITS=6, load dat_bcd=0x001234, neg=0, dp_pos=2, ready always 1 -> 8 chars on consecutive cycles starting the cycle after load: 20 20 20 31 32 2E 33 34; first_o on the 1st char, last_o on the 8th; busy_o falls 1 cycle after the last transfer.
- dat_bcd=0x000000, neg=1, dp_pos=0 -> 7 chars: 2D 20 20 20 20 20 30 (digit 0 never blanked); with BCD_CHAR_ZERO_BLANK_EN undefined -> 2D 30 30 30 30 30 30.
- dat_bcd=0x000005, dp_pos=3 -> 20 20 20 30 2E 30 30 35 (no blanking at or right of the point's left digit).
- Backpressure: ready toggles 1,0,0,1,... during the first frame -> char_o stable across stalls; total transfers still 8; no duplicate or skipped characters.
- load_i pulsed at the 3rd character of a frame -> overrun_o high exactly 1 cycle; current frame unaltered; dat_bcd=0x00A001 -> digit 0xA emitted as 3F.
- rst_n_i asserted low mid-frame (asynchronously, between clock edges) -> char_valid_o, busy_o, first_o and last_o go 0 immediately; after release, no characters until the next load_i.

Source files
------------

// File: rtl/bcd_char_serializer_if.sv
// Character-frame bus between the BCD converter, the serializer and the text renderer.
// The slave modport is the serializer's view; the master modport drives loads and accepts characters.
interface bcd_char_serializer_if #(
    parameter int DIGITS = 6,
    parameter int DP_W   = 4
);
    logic                  load_i;
    logic [4*DIGITS-1:0]   dat_bcd_i;
    logic                  neg_i;
    logic [DP_W-1:0]       dp_pos_i;
    logic [7:0]            char_o;
    logic                  char_valid_o;
    logic                  char_ready_i;
    logic                  first_o;
    logic                  last_o;

    modport master (
        output load_i, dat_bcd_i, neg_i, dp_pos_i, char_ready_i,
        input  char_o, char_valid_o, first_o, last_o
    );

    modport slave (
        input  load_i, dat_bcd_i, neg_i, dp_pos_i, char_ready_i,
        output char_o, char_valid_o, first_o, last_o
    );
endinterface

// File: rtl/bcd_char_serializer.sv
// Turns a latched BCD readout into an ASCII frame: sign, digits MSB first, optional decimal point.
// Define BCD_CHAR_ZERO_BLANK_EN to blank leading zeros to the left of the decimal point.
module bcd_char_serializer #(
    parameter int DIGITS = 6,
    parameter int DP_W   = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    bcd_char_serializer_if.slave  bus,
    output logic                  busy_o,
    output logic                  overrun_o
);
    typedef enum logic [2:0] {IDLE, SIGN, DIGIT, POINT, DRAIN} state_t;

    state_t              state;
    state_t              state_nxt;
    logic [4*DIGITS-1:0] dat_q;
    logic                neg_q;
    logic [3:0]          dp_q;
    logic [3:0]          dp_clamped;
    logic [3:0]          idx;
    logic [3:0]          idx_nxt;
    logic [3:0]          cur_digit;
    logic                transfer;
    logic                load_ok;
`ifdef BCD_CHAR_ZERO_BLANK_EN
    logic                nz_seen;
    logic                nz_nxt;
`endif

    // A point position past the top digit would never be reached, so pin it to the leftmost slot.
    assign dp_clamped = (32'(bus.dp_pos_i) >= 32'(DIGITS)) ? 4'(DIGITS - 1) : 4'(bus.dp_pos_i);
    assign transfer   = bus.char_valid_o && bus.char_ready_i;
    assign load_ok    = (state == IDLE) && bus.load_i;

    always_comb begin
        cur_digit = 4'd0;
        for (int k = 0; k < DIGITS; k++) begin
            if (idx == 4'(k)) cur_digit = dat_q[4*k +: 4];
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state     <= IDLE;
            idx       <= 4'd0;
            dat_q     <= '0;
            neg_q     <= 1'b0;
            dp_q      <= 4'd0;
            overrun_o <= 1'b0;
`ifdef BCD_CHAR_ZERO_BLANK_EN
            nz_seen   <= 1'b0;
`endif
        end else begin
            state     <= state_nxt;
            idx       <= idx_nxt;
            overrun_o <= bus.load_i && (state != IDLE);
`ifdef BCD_CHAR_ZERO_BLANK_EN
            nz_seen   <= nz_nxt;
`endif
            if (load_ok) begin
                dat_q <= bus.dat_bcd_i;
                neg_q <= bus.neg_i;
                dp_q  <= dp_clamped;
            end
        end
    end

    always_comb begin
        state_nxt        = state;
        idx_nxt          = idx;
        bus.char_o       = 8'h00;
        bus.char_valid_o = 1'b0;
        bus.first_o      = 1'b0;
        bus.last_o       = 1'b0;
        busy_o           = 1'b0;
`ifdef BCD_CHAR_ZERO_BLANK_EN
        nz_nxt           = nz_seen;
`endif
        case (state)
            IDLE: begin
                if (bus.load_i) begin
                    state_nxt = SIGN;
                    idx_nxt   = 4'(DIGITS - 1);
`ifdef BCD_CHAR_ZERO_BLANK_EN
                    nz_nxt    = 1'b0;
`endif
                end
            end
            SIGN: begin
                bus.char_valid_o = 1'b1;
                busy_o           = 1'b1;
                bus.first_o      = 1'b1;
                bus.char_o       = neg_q ? 8'h2D : 8'h20;
                if (transfer) state_nxt = DIGIT;
            end
            DIGIT: begin
                bus.char_valid_o = 1'b1;
                busy_o           = 1'b1;
                bus.last_o       = (idx == 4'd0);
                bus.char_o       = (cur_digit > 4'd9) ? 8'h3F : {4'h3, cur_digit};
`ifdef BCD_CHAR_ZERO_BLANK_EN
                // Digit 0 and anything at or right of the point always show as numerals.
                if (!nz_seen && cur_digit == 4'd0 && idx > dp_q && idx != 4'd0) bus.char_o = 8'h20;
                if (transfer && bus.char_o != 8'h20) nz_nxt = 1'b1;
`endif
                if (transfer) begin
                    if (idx == 4'd0) begin
                        state_nxt = DRAIN;
                    end else if (dp_q != 4'd0 && idx == dp_q) begin
                        state_nxt = POINT;
                    end else begin
                        idx_nxt = idx - 4'd1;
                    end
                end
            end
            POINT: begin
                bus.char_valid_o = 1'b1;
                busy_o           = 1'b1;
                bus.char_o       = 8'h2E;
                if (transfer) begin
                    idx_nxt   = idx - 4'd1;
                    state_nxt = DIGIT;
                end
            end
            DRAIN: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end
endmodule

// File: tb/tb_bcd_char_serializer.sv
// Scoreboard bench for bcd_char_serializer: a frame model fills the queue, a negedge monitor drains it.
module tb_bcd_char_serializer;
    localparam int DIGITS = 6;
    localparam int DP_W   = 4;

    logic clk_i = 1'b0;
    logic rst_n_i;
    logic busy_o;
    logic overrun_o;

    bcd_char_serializer_if #(.DIGITS(DIGITS), .DP_W(DP_W)) bus();

    bcd_char_serializer #(.DIGITS(DIGITS), .DP_W(DP_W)) dut (
        .clk_i     (clk_i),
        .rst_n_i   (rst_n_i),
        .bus       (bus),
        .busy_o    (busy_o),
        .overrun_o (overrun_o)
    );

    always #5 clk_i = ~clk_i;

    int          checks = 0;
    int          errors = 0;
    logic [9:0]  exp_q[$];
    int          overrun_cnt = 0;
    int          overrun_exp = 0;
    int          ready_mode = 0;
    int          pat_cnt = 0;
    bit          stalled = 0;
    bit          expect_drain = 0;
    logic [10:0] held;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s got %0h expected %0h", name, actual, expected);
        end
    endtask

    // Expected frame built directly from the readout rules: sign, digits MSB first, point after digit dp.
    task automatic pushFrame(input logic [4*DIGITS-1:0] dat, input logic neg, input logic [DP_W-1:0] dp);
        int dpc;
        int v;
        logic [7:0] c;
`ifdef BCD_CHAR_ZERO_BLANK_EN
        bit leading;
        leading = 1'b1;
`endif
        dpc = (int'(dp) >= DIGITS) ? DIGITS - 1 : int'(dp);
        exp_q.push_back({1'b1, 1'b0, (neg ? 8'h2D : 8'h20)});
        for (int k = DIGITS - 1; k >= 0; k--) begin
            v = int'(dat[4*k +: 4]);
            c = (v > 9) ? 8'h3F : 8'(8'h30 + v);
`ifdef BCD_CHAR_ZERO_BLANK_EN
            if (leading && v == 0 && k > dpc && k > 0) c = 8'h20;
            else leading = 1'b0;
`endif
            exp_q.push_back({1'b0, (k == 0), c});
            if (dpc != 0 && k == dpc) exp_q.push_back({2'b00, 8'h2E});
        end
    endtask

    task automatic applyStimulus(input logic [4*DIGITS-1:0] dat, input logic neg, input logic [DP_W-1:0] dp);
        @(posedge clk_i); #1;
        bus.load_i    = 1'b1;
        bus.dat_bcd_i = dat;
        bus.neg_i     = neg;
        bus.dp_pos_i  = dp;
        pushFrame(dat, neg, dp);
        @(posedge clk_i); #1;
        bus.load_i = 1'b0;
        @(negedge clk_i);
        checkOutput("first_latency", {bus.char_valid_o, bus.first_o, busy_o}, 3'b111);
    endtask

    task automatic waitDone();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 400) begin
            @(negedge clk_i);
            n++;
        end
        if (exp_q.size() != 0) begin
            checkOutput("frame_timeout", 32'(exp_q.size()), 0);
            exp_q.delete();
        end
        @(posedge clk_i);
        @(posedge clk_i);
    endtask

    initial begin
        bus.char_ready_i = 1'b0;
        forever begin
            @(posedge clk_i); #1;
            case (ready_mode)
                0: bus.char_ready_i = 1'b1;
                1: bus.char_ready_i = 1'($urandom_range(0, 1));
                default: begin
                    bus.char_ready_i = (pat_cnt % 3 == 0);
                    pat_cnt++;
                end
            endcase
        end
    end

    // Monitor: pops one expected character per accepted transfer and checks stall stability.
    always @(negedge clk_i) begin
        logic [9:0] e;
        if (!rst_n_i) begin
            stalled      = 0;
            expect_drain = 0;
        end else begin
            if (expect_drain) begin
                checkOutput("busy_fall", {busy_o, bus.char_valid_o}, 2'b00);
                expect_drain = 0;
            end
            if (stalled)
                checkOutput("stall_hold", {bus.char_valid_o, bus.first_o, bus.last_o, bus.char_o}, held);
            stalled = 0;
            if (overrun_o) overrun_cnt++;
            if (bus.char_valid_o) begin
                if (!bus.char_ready_i) begin
                    stalled = 1;
                    held    = {bus.char_valid_o, bus.first_o, bus.last_o, bus.char_o};
                end else if (exp_q.size() == 0) begin
                    checkOutput("unexpected_char", {1'b1, bus.char_o}, 0);
                end else begin
                    e = exp_q.pop_front();
                    checkOutput("char", {bus.first_o, bus.last_o, bus.char_o}, e);
                    if (e[8]) expect_drain = 1;
                end
            end
        end
    end

    initial begin
        logic [4*DIGITS-1:0] d;
        rst_n_i       = 1'b0;
        bus.load_i    = 1'b0;
        bus.dat_bcd_i = '0;
        bus.neg_i     = 1'b0;
        bus.dp_pos_i  = '0;
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        rst_n_i = 1'b1;
        @(negedge clk_i);
        checkOutput("reset_state", {bus.char_o, bus.char_valid_o, bus.first_o, bus.last_o, busy_o, overrun_o}, 0);

        ready_mode = 0;
        applyStimulus(24'h001234, 1'b0, 4'd2); waitDone();
        applyStimulus(24'h000000, 1'b1, 4'd0); waitDone();
        applyStimulus(24'h000005, 1'b0, 4'd3); waitDone();
        applyStimulus(24'h987654, 1'b1, 4'd9); waitDone();

        ready_mode = 2;
        pat_cnt    = 0;
        applyStimulus(24'h001234, 1'b0, 4'd2); waitDone();

        // Extra load on the third character must be rejected with a single overrun pulse.
        ready_mode = 0;
        applyStimulus(24'h00A001, 1'b0, 4'd0);
        @(posedge clk_i); #1;
        @(posedge clk_i); #1;
        bus.load_i    = 1'b1;
        bus.dat_bcd_i = 24'h777777;
        @(posedge clk_i); #1;
        bus.load_i = 1'b0;
        overrun_exp++;
        waitDone();
        checkOutput("overrun_pulse", 32'(overrun_cnt), 32'(overrun_exp));

        ready_mode = 1;
        for (int f = 0; f < 20; f++) begin
            int nlead;
            nlead = $urandom_range(0, DIGITS);
            d = '0;
            for (int k = 0; k < DIGITS - nlead; k++)
                d[4*k +: 4] = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
            applyStimulus(d, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 7)));
            waitDone();
        end

        // Asynchronous reset mid-frame, between clock edges.
        applyStimulus(24'h123456, 1'b1, 4'd1);
        repeat (3) @(negedge clk_i);
        #2 rst_n_i = 1'b0;
        #1;
        checkOutput("async_reset", {bus.char_valid_o, busy_o, bus.first_o, bus.last_o}, 4'b0000);
        exp_q.delete();
        @(posedge clk_i);
        @(negedge clk_i);
        rst_n_i = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk_i);
            checkOutput("quiet_after_reset", {bus.char_valid_o, busy_o}, 2'b00);
        end

        checkOutput("overrun_total", 32'(overrun_cnt), 32'(overrun_exp));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
